// File: rtl/hamming_helper_encoder.sv
// Sequential Hamming(15,11) helper-data encoder for PUF enrollment.
// Walks a response of NUM_BLOCKS 11-bit blocks, one block per enabled clock,
// and accumulates 4 parity bits per block into the helper word o_helper.
// The bit ordering and parity equations follow the codeword layout that the
// reconstruction-side decoder expects:
//   codeword positions 1..15 = p0,p1,d0,p2,d1,d2,d3,p3,d4..d10
//   block k data  d_j = i_Data[11k+10-j]
//   block k parity p_j -> o_helper[4k+3-j]
// Optional build macro: HAMMING_EXT_PARITY_EN adds o_ext_parity, one overall
// (SECDED) parity bit per block, written together with that block's parity.
// CNT_W must satisfy 2**CNT_W >= NUM_BLOCKS.

module hamming_helper_encoder #(
    parameter int NUM_BLOCKS = 24,
    parameter int CNT_W      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        start,
    input  logic [0:11*NUM_BLOCKS-1]    i_Data,
    output logic                        busy,
    output logic                        done,
    output logic [0:4*NUM_BLOCKS-1]     o_helper
`ifdef HAMMING_EXT_PARITY_EN
    ,
    output logic [0:NUM_BLOCKS-1]       o_ext_parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Parity nibble {p3,p2,p1,p0} of an 11-bit block whose bit j is d_j.
    function automatic logic [3:0] hamming_parity(input logic [10:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        return p;
    endfunction

    // Overall parity of the full 15-bit codeword (data plus Hamming parity).
    function automatic logic overall_parity(input logic [10:0] d, input logic [3:0] p);
        return (^d) ^ (^p);
    endfunction

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic                        busy_r;
    logic                        done_r;
    logic [0:4*NUM_BLOCKS-1]     helper_r;

    int                          cnt_idx_s;
    logic [10:0]                 blk_s;
    logic [3:0]                  par_s;
    logic                        last_blk_s;

    assign cnt_idx_s = int'(cnt_r);

    // Select the current block and derive its parity nibble.
    always_comb begin
        // The ascending source range puts i_Data[11k] (d10) at blk_s[10]
        // and i_Data[11k+10] (d0) at blk_s[0], so blk_s[j] is d_j.
        blk_s      = i_Data[11*cnt_idx_s +: 11];
        par_s      = hamming_parity(blk_s);
        last_blk_s = (cnt_r == CNT_W'(NUM_BLOCKS - 1));
    end

    // Control FSM, block counter and helper-word accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            helper_r <= {(4*NUM_BLOCKS){1'b0}};
        end else if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_ENCODE;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_ENCODE: begin
                    // Nibble MSB lands on the lowest index, i.e. p3 at 4k.
                    helper_r[4*cnt_idx_s +: 4] <= par_s;
                    if (last_blk_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r <= ST_ENCODE;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign o_helper = helper_r;

`ifdef HAMMING_EXT_PARITY_EN
    logic [0:NUM_BLOCKS-1]       ext_r;

    // Overall codeword parity per block, captured alongside the helper nibble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_r <= {NUM_BLOCKS{1'b0}};
        end else if (enable && (state_r == ST_ENCODE)) begin
            ext_r[cnt_idx_s] <= overall_parity(blk_s, par_s);
        end
    end

    assign o_ext_parity = ext_r;
`endif

endmodule

// File: doc/hamming_helper_encoder.md
Name: hamming_helper_encoder

Overview:
- Sequential Hamming(15,11) encoder. Generates the 96-bit helper (parity) word for a 264-bit PUF response during enrollment.
- Processes 24 blocks of 11 data bits, one block per enabled clock, producing 4 parity bits per block.
- Its output is the helper data consumed by the PUF-side ECC decoder at reconstruction. Bit ordering and parity equations are fixed here to match that decoder's codeword layout.

Parameters:
- NUM_BLOCKS, 24, number of 11-bit data blocks; i_Data width = 11*NUM_BLOCKS, o_helper width = 4*NUM_BLOCKS.
- CNT_W, 5, block counter width; must satisfy 2**CNT_W >= NUM_BLOCKS.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  clock-enable; when 0, all state holds, including the counter and FSM.
- start  input  1  single-cycle request to encode; sampled only in IDLE or DONE with enable=1.
- i_Data  input  [0:263]  response to encode; must be held stable from start until done.
- busy  output  1  high while in ENCODE.
- done  output  1  high in DONE; held until the next accepted start or reset.
- o_helper  output  [0:95]  helper parity word; valid while done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, busy=0, done=0, o_helper=all zeros.
- FSM states: IDLE, ENCODE, DONE.
  - IDLE -> ENCODE on enable&start: counter<=0, busy<=1. o_helper is not cleared.
  - ENCODE, each enable=1 cycle:
    - Compute parity of block k=counter and write o_helper[4k+:4].
    - If k==NUM_BLOCKS-1: go to DONE, busy<=0, done<=1. Otherwise counter<=counter+1.
  - DONE -> ENCODE on enable&start: done<=0, busy<=1, counter<=0. Otherwise hold DONE.
- Latency: done rises on the NUM_BLOCKS-th enabled edge after the start edge. Default: 24 enabled cycles after start acceptance.
- enable=0 mid-ENCODE: freeze; resume at the same block with no skip or repeat.
- start while in ENCODE: ignored.
- Reset mid-ENCODE: immediate return to IDLE; partial o_helper is discarded (zeroed).
- Block bit mapping for block k:
  - data d_j = i_Data[11k+10-j], j=0..10 (d10 is the MSB, at the lowest index).
  - parity p_j lands in o_helper[4k+3-j], j=0..3.
- Parity equations (codeword positions 1..15 = p0,p1,d0,p2,d1,d2,d3,p3,d4..d10):
  - p0 = d0^d1^d3^d4^d6^d8^d10
  - p1 = d0^d2^d3^d5^d6^d9^d10
  - p2 = d1^d2^d3^d7^d8^d9^d10
  - p3 = d4^d5^d6^d7^d8^d9^d10
- Parity computation is combinational on the selected block and registered into o_helper. No other output changes except as listed above.
- The counter never exceeds NUM_BLOCKS-1; there is no wrap-around within an encode.

Optional Feature:
- Macro: HAMMING_EXT_PARITY_EN.
- Defined:
  - Adds output o_ext_parity [0:NUM_BLOCKS-1]. Bit k = XOR of the 11 data bits and 4 parity bits of block k (SECDED overall parity).
  - Written in the same cycle as o_helper[4k+:4]; reset to 0.
- Undefined:
  - Port absent; no extra logic.
  - All other behaviour is identical.

Test Plan:
- Reset released, i_Data=0, start pulse -> busy=1 for 24 cycles; then done=1, busy=0, o_helper=96'h0.
- i_Data all ones -> every p_j=1; o_helper=all ones. With HAMMING_EXT_PARITY_EN, o_ext_parity=all ones (15 ones per block).
- Only i_Data[10]=1 (block 0, d0) -> o_helper[3]=1, o_helper[2]=1, all other bits 0. Repeat with i_Data[11*23+0]=1 (block 23, d10) -> o_helper[92:95]=4'b1111.
- Random i_Data with enable toggled 0/1 every other cycle -> same o_helper as the golden model; done asserts after exactly 24 enabled edges.
- reset=0 pulsed at block 10 of an encode -> outputs zero immediately; a fresh start then yields the correct full result.
- start asserted during ENCODE, and again in DONE -> ignored during ENCODE; in DONE, done drops next cycle and re-encode completes with correct helper.
